instr_fetch: RTL and testbench
==============================

// Module: instr_fetch
// PURPOSE
//  Fetch stage upstream of Decode/Extend: owns PC, issues word reads to instruction
//  memory over a req/gnt + rvalid interface, and presents Instr[31:0] plus PC/PCPlus4
//  to Decode and Extend through a one-entry valid/ready output register.
//  Redirects (taken branch/jump, PCTarget = PC + ImmExt) flush in-flight fetches.
// PARAMETERS
//  RESET_PC  32'h0000_0000  PC fetched first after reset release; must be 4-byte aligned
// PORTS
//  clk            in   1   single clock, all state on rising edge
//  reset          in   1   asynchronous, active-low; asserted (0) clears all state
//  PCSrc          in   1   redirect pulse from execute: take PCTarget
//  PCTarget       in   32  redirect address (PC + ImmExt)
//  imem_req       out  1   read request to instruction memory
//  imem_addr      out  32  word address of request, bits[1:0] always 2'b00
//  imem_gnt       in   1   request accepted this cycle (req & gnt = handshake)
//  imem_rvalid    in   1   read data valid; exactly one per granted request, >=1 cycle after gnt
//  imem_rdata     in   32  instruction word
//  instr_valid    out  1   Instr/PC/PCPlus4 valid for Decode
//  instr_ready    in   1   Decode accepts (instr_valid & instr_ready = consume)
//  Instr          out  32  fetched instruction (Extend consumes Instr[31:7])
//  PC             out  32  address of Instr
//  PCPlus4        out  32  PC + 4, modulo 2^32
//  fetch_misalign out  1   sticky: redirect to non-word-aligned target occurred
// BEHAVIOUR
//  - Reset (reset=0): FSM=S_REQ, fetch_pc=RESET_PC, instr_valid=0, Instr=0, PC=0,
//    PCPlus4=4, imem_req=0 during reset, drop=0, fetch_misalign=0.
//  - FSM: S_REQ  : imem_req=1, imem_addr=fetch_pc. gnt -> S_WAIT.
//         S_WAIT : await rvalid. rvalid&drop -> discard, drop=0, S_REQ.
//                  rvalid&!drop -> load out reg (Instr=rdata, PC=fetch_pc), fetch_pc+=4,
//                  -> S_REQ if out reg now free else S_FULL.
//         S_FULL : instr_valid=1, imem_req=0; consume -> S_REQ.
//         S_HALT : entered on misaligned redirect; imem_req=0, instr_valid=0 until reset.
//  - Out reg loads only when empty or consumed same cycle; holds stable while
//    instr_valid & !instr_ready. Max one request outstanding.
//  - Latency: req+gnt cycle t, rvalid t+1 -> instr_valid at t+2. Peak rate 1 per 2 cycles.
//  - fetch_pc increments wrap 32'hFFFF_FFFC -> 0 silently; PCPlus4 wraps likewise.
//  - Redirect (PCSrc=1), any state except S_HALT, highest priority:
//    instr_valid<=0 (current output flushed, even if consumed same cycle);
//    fetch_pc<=PCTarget; S_REQ w/o gnt: imem_addr switches next cycle (memory
//    allows un-granted requests to change); S_REQ with gnt same cycle or S_WAIT
//    without rvalid: drop<=1, -> S_WAIT; S_WAIT with rvalid same cycle: data discarded, -> S_REQ;
//    S_FULL: -> S_REQ.
//  - PCTarget[1:0]!=0 with PCSrc: fetch_misalign<=1, -> S_HALT; outstanding rvalid still
//    absorbed (no output). No further requests.
//  - Reset assertion mid-transaction: state cleared immediately; memory is reset with
//    the same reset, so no stale rvalid arrives after release.
// STRUCTURE
//  - Shared package: FSM state encoding (S_REQ, S_WAIT, S_FULL, S_HALT, 2 bits),
//    RESET_PC default, instruction width 32, PC increment constant 4.
//  - One sub-module: fetch_out_reg (one-entry valid/ready register, flush input),
//    holding Instr/PC/PCPlus4. FSM, fetch_pc, drop flag stay in instr_fetch.
// TESTING
//  - Reset release, gnt=1 always, rvalid 1 cycle after gnt, ready=1: Instr/PC sequence
//    PC=0,4,8,... with instr_valid every 2nd cycle; first instr_valid 2 cycles after req.
//  - instr_ready=0 for 5 cycles with instr_valid=1: Instr/PC stable, imem_req=0, no
//    PC skipped after ready returns.
//  - PCSrc=1, PCTarget=32'h100 while S_WAIT: returned word dropped, next req addr
//    32'h100, next instr_valid has PC=32'h100, PCPlus4=32'h104.
//  - PCSrc with gnt same cycle and with rvalid same cycle: neither stale word nor old
//    PC reaches Decode; next output PC = PCTarget.
//  - PCTarget=32'h102: fetch_misalign=1, imem_req=0 and instr_valid=0 until reset.
//  - RESET_PC=32'hFFFF_FFF8: PCs FFFF_FFF8, FFFF_FFFC, 0000_0000; PCPlus4 of
//    FFFF_FFFC is 0; async reset mid-S_WAIT clears instr_valid without a clock edge.

Source files
------------

// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction fetch stage.
//  - fetch_state_e : fetch FSM state encoding (2 bits)
//  - XLEN          : instruction / address width
//  - PC_INC        : sequential PC step (one 32-bit word)
//  - RESET_PC_DEFAULT : default first fetch address after reset
//  - pc_next()     : sequential successor of a PC, wrapping modulo 2^32
package instr_fetch_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] PC_INC           = 32'd4;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_FULL = 2'd2,
    S_HALT = 2'd3
  } fetch_state_e;

  function automatic logic [XLEN-1:0] pc_next(input logic [XLEN-1:0] pc);
    return pc + PC_INC;
  endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Bus bundle between the fetch stage, instruction memory and Decode/Extend.
//  Memory side : imem_req/imem_addr (fetch -> mem), imem_gnt/imem_rvalid/imem_rdata (mem -> fetch)
//  Decode side : instr_valid/Instr/PC/PCPlus4 (fetch -> decode), instr_ready (decode -> fetch)
//  master = fetch stage, slave = memory + decode environment.
interface instr_fetch_if;
  import instr_fetch_pkg::*;

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_gnt;
  logic            imem_rvalid;
  logic [XLEN-1:0] imem_rdata;

  logic            instr_valid;
  logic            instr_ready;
  logic [XLEN-1:0] Instr;
  logic [XLEN-1:0] PC;
  logic [XLEN-1:0] PCPlus4;

  modport master (
    output imem_req, imem_addr,
    input  imem_gnt, imem_rvalid, imem_rdata,
    output instr_valid, Instr, PC, PCPlus4,
    input  instr_ready
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_gnt, imem_rvalid, imem_rdata,
    input  instr_valid, Instr, PC, PCPlus4,
    output instr_ready
  );

endinterface

// File: rtl/instr_fetch_out_reg.sv
// One-entry valid/ready output register holding Instr/PC/PCPlus4 for Decode.
//  clk, reset    : clock, asynchronous active-low reset
//  flush         : drop the held entry (wins over load and consume)
//  load          : capture load_instr/load_pc; only issued when free is high
//  ready         : downstream accept (valid & ready = consume)
//  valid/instr/pc/pc_plus4 : held entry, stable while valid & !ready
//  free          : entry empty or being consumed this cycle
module fetch_out_reg
  import instr_fetch_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            load,
  input  logic [XLEN-1:0] load_instr,
  input  logic [XLEN-1:0] load_pc,
  input  logic            ready,
  output logic            valid,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic            free
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid    <= 1'b0;
      instr    <= '0;
      pc       <= '0;
      pc_plus4 <= PC_INC;
    end else begin
      if (flush) begin
        valid <= 1'b0;
      end else if (load) begin
        valid <= 1'b1;
      end else if (ready) begin
        valid <= 1'b0;
      end
      if (load && !flush) begin
        instr    <= load_instr;
        pc       <= load_pc;
        pc_plus4 <= pc_next(load_pc);
      end
    end
  end

  always_comb begin
    free = !valid || ready;
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the fetch PC, issues word reads over a req/gnt +
// rvalid memory port, and hands Instr/PC/PCPlus4 to Decode via a one-entry
// valid/ready output register. Redirects flush the output and in-flight fetches.
//  clk, reset     : clock, asynchronous active-low reset
//  PCSrc/PCTarget : redirect pulse and target address from execute
//  bus (master)   : memory request/response and Decode handshake
//  fetch_misalign : sticky flag, set by a redirect to a non-word-aligned target
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              PCSrc,
  input  logic [XLEN-1:0]   PCTarget,
  instr_fetch_if.master     bus,
  output logic              fetch_misalign
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic            drop_q, drop_d;
  logic            misalign_q, misalign_d;

  logic            out_free;
  logic            out_load;
  logic            redirect;
  logic            target_aligned;
  logic            handshake;
  logic            in_flight;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_REQ;
      fetch_pc_q <= RESET_PC;
      drop_q     <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      drop_q     <= drop_d;
      misalign_q <= misalign_d;
    end
  end

  always_comb begin
    // A request is only issued when the output register will be able to take
    // the returning word; a full, stalled output parks the FSM in S_FULL.
    bus.imem_req   = reset && (state_q == S_REQ) && out_free;
    bus.imem_addr  = fetch_pc_q;
    handshake      = bus.imem_req && bus.imem_gnt;
    redirect       = PCSrc && (state_q != S_HALT);
    target_aligned = (PCTarget[1:0] == 2'b00);
    // A read remains outstanding after this cycle: it is granted now, or we are
    // still waiting for its data.
    in_flight      = ((state_q == S_REQ) && handshake) ||
                     ((state_q == S_WAIT) && !bus.imem_rvalid);

    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    drop_d     = drop_q;
    misalign_d = misalign_q;
    out_load   = 1'b0;

    case (state_q)
      S_REQ: begin
        if (handshake) begin
          state_d = S_WAIT;
        end else if (!out_free) begin
          state_d = S_FULL;
        end
      end
      S_WAIT: begin
        if (bus.imem_rvalid) begin
          state_d = S_REQ;
          if (drop_q) begin
            drop_d = 1'b0;
          end else begin
            out_load   = 1'b1;
            fetch_pc_d = pc_next(fetch_pc_q);
          end
        end
      end
      S_FULL: begin
        if (out_free) begin
          state_d = S_REQ;
        end
      end
      S_HALT: begin
        if (bus.imem_rvalid) begin
          drop_d = 1'b0;
        end
      end
    endcase

    // Redirect overrides everything above: any read still in flight is marked
    // for discard, and the output register is flushed.
    if (redirect) begin
      out_load = 1'b0;
      drop_d   = in_flight;
      if (target_aligned) begin
        fetch_pc_d = PCTarget;
        state_d    = in_flight ? S_WAIT : S_REQ;
      end else begin
        misalign_d = 1'b1;
        state_d    = S_HALT;
      end
    end
  end

  fetch_out_reg u_out_reg (
    .clk        (clk),
    .reset      (reset),
    .flush      (redirect),
    .load       (out_load),
    .load_instr (bus.imem_rdata),
    .load_pc    (fetch_pc_q),
    .ready      (bus.instr_ready),
    .valid      (bus.instr_valid),
    .instr      (bus.Instr),
    .pc         (bus.PC),
    .pc_plus4   (bus.PCPlus4),
    .free       (out_free)
  );

  always_comb begin
    fetch_misalign = misalign_q;
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: stimulus pushes expected PC/PCPlus4 pairs,
// a monitor pops and compares on every Decode consume. A second instance with
// RESET_PC = FFFF_FFF8 exercises PC wrap-around.
module tb_instr_fetch;
  import instr_fetch_pkg::*;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc4;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        PCSrc;
  logic [31:0] PCTarget;
  logic        fetch_misalign;
  logic        w_misalign;

  instr_fetch_if bus ();
  instr_fetch_if wbus ();

  int   total = 0;
  int   bad = 0;
  int   budget = 0;
  int   rv_delay = 1;
  int   widx = 0;
  exp_t exp_q[$];
  exp_t e;

  logic [31:0] wexp_pc [3] = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
  logic [31:0] wexp_pc4[3] = '{32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};

  instr_fetch u_dut (
    .clk            (clk),
    .reset          (reset),
    .PCSrc          (PCSrc),
    .PCTarget       (PCTarget),
    .bus            (bus),
    .fetch_misalign (fetch_misalign)
  );

  instr_fetch #(.RESET_PC(32'hFFFF_FFF8)) u_wrap (
    .clk            (clk),
    .reset          (reset),
    .PCSrc          (1'b0),
    .PCTarget       (32'h0),
    .bus            (wbus),
    .fetch_misalign (w_misalign)
  );

  assign bus.imem_gnt  = (budget > 0);
  assign wbus.imem_gnt = 1'b1;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] pc, input logic [31:0] pc4);
    exp_t x;
    x.pc  = pc;
    x.pc4 = pc4;
    exp_q.push_back(x);
  endtask

  task automatic wait_req(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      seen = bus.imem_req;
    end
    chk(name, 32'(seen), 32'd1);
  endtask

  task automatic wait_valid(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      seen = bus.instr_valid;
    end
    chk(name, 32'(seen), 32'd1);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(posedge clk);
    @(posedge clk);
    #2;
    chk(name, 32'(exp_q.size()), 32'd0);
  endtask

  // Main memory model: one response rv_delay cycles after each grant.
  initial begin : mem_main
    logic        hs;
    logic [31:0] a;
    logic        pend;
    logic [31:0] paddr;
    int          wcnt;
    pend = 1'b0;
    paddr = '0;
    wcnt = 0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = '0;
    forever begin
      @(negedge clk);
      hs = reset && bus.imem_req && bus.imem_gnt;
      a  = bus.imem_addr;
      @(posedge clk);
      #1;
      bus.imem_rvalid = 1'b0;
      if (!reset) begin
        pend = 1'b0;
      end else begin
        if (hs) begin
          budget = budget - 1;
          pend   = 1'b1;
          paddr  = a;
          wcnt   = rv_delay;
        end
        if (pend) begin
          wcnt = wcnt - 1;
          if (wcnt <= 0) begin
            bus.imem_rvalid = 1'b1;
            bus.imem_rdata  = mem_word(paddr);
            pend            = 1'b0;
          end
        end
      end
    end
  end

  // Wrap-instance memory: always grants, data one cycle later.
  initial begin : mem_wrap
    logic        hs;
    logic [31:0] a;
    wbus.imem_rvalid = 1'b0;
    wbus.imem_rdata  = '0;
    forever begin
      @(negedge clk);
      hs = reset && wbus.imem_req;
      a  = wbus.imem_addr;
      @(posedge clk);
      #1;
      wbus.imem_rvalid = reset && hs;
      wbus.imem_rdata  = mem_word(a);
    end
  end

  // Scoreboard monitor for the main instance.
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (reset && bus.instr_valid && bus.instr_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL sb_unexpected: got PC %h want no output", bus.PC);
        end else begin
          e = exp_q.pop_front();
          chk("sb_pc", bus.PC, e.pc);
          chk("sb_pc4", bus.PCPlus4, e.pc4);
          chk("sb_instr", bus.Instr, mem_word(e.pc));
        end
      end
    end
  end

  // Wrap-instance monitor: first three outputs only.
  initial begin : wrap_monitor
    forever begin
      @(negedge clk);
      if (reset && wbus.instr_valid && widx < 3) begin
        chk("wrap_pc", wbus.PC, wexp_pc[widx]);
        chk("wrap_pc4", wbus.PCPlus4, wexp_pc4[widx]);
        chk("wrap_instr", wbus.Instr, mem_word(wexp_pc[widx]));
        widx++;
      end
    end
  end

  initial begin : stimulus
    reset            = 1'b0;
    PCSrc            = 1'b0;
    PCTarget         = '0;
    bus.instr_ready  = 1'b1;
    wbus.instr_ready = 1'b1;

    // Reset values
    @(posedge clk);
    @(posedge clk);
    #2;
    chk("rst_valid", 32'(bus.instr_valid), 32'd0);
    chk("rst_req", 32'(bus.imem_req), 32'd0);
    chk("rst_instr", bus.Instr, 32'h0);
    chk("rst_pc", bus.PC, 32'h0);
    chk("rst_pc4", bus.PCPlus4, 32'h4);
    chk("rst_misalign", 32'(fetch_misalign), 32'd0);
    chk("rst_wrap_req", 32'(wbus.imem_req), 32'd0);
    chk("rst_wrap_misalign", 32'(w_misalign), 32'd0);

    // Sequential stream, latency: req at c0, valid at c2
    push(32'h0, 32'h4);
    push(32'h4, 32'h8);
    push(32'h8, 32'hC);
    push(32'hC, 32'h10);
    budget = 4;
    reset  = 1'b1;
    @(negedge clk);
    chk("lat_req", 32'(bus.imem_req), 32'd1);
    chk("lat_addr", bus.imem_addr, 32'h0);
    @(negedge clk);
    chk("lat_valid_c1", 32'(bus.instr_valid), 32'd0);
    @(negedge clk);
    chk("lat_valid_c2", 32'(bus.instr_valid), 32'd1);
    drain("drain_seq");

    // Backpressure: output held, no requests, nothing skipped
    push(32'h10, 32'h14);
    push(32'h14, 32'h18);
    push(32'h18, 32'h1C);
    bus.instr_ready = 1'b0;
    budget = 3;
    wait_valid("stall_wait_valid");
    repeat (5) begin
      chk("stall_valid", 32'(bus.instr_valid), 32'd1);
      chk("stall_pc", bus.PC, 32'h10);
      chk("stall_instr", bus.Instr, mem_word(32'h10));
      chk("stall_req", 32'(bus.imem_req), 32'd0);
      @(negedge clk);
    end
    @(posedge clk);
    #2;
    bus.instr_ready = 1'b1;
    drain("drain_stall");

    // Redirect while waiting, data not yet back
    push(32'h100, 32'h104);
    budget   = 1;
    rv_delay = 3;
    wait_req("c1_wait_req");
    @(posedge clk);
    #2;
    PCSrc    = 1'b1;
    PCTarget = 32'h100;
    budget   = 1;
    rv_delay = 1;
    @(posedge clk);
    #2;
    PCSrc = 1'b0;
    wait_req("c1_wait_req2");
    chk("c1_redir_addr", bus.imem_addr, 32'h100);
    drain("drain_c1");

    // Redirect in the grant cycle
    push(32'h200, 32'h204);
    budget = 2;
    wait_req("c2_wait_req");
    PCSrc    = 1'b1;
    PCTarget = 32'h200;
    @(posedge clk);
    #2;
    PCSrc = 1'b0;
    drain("drain_c2");

    // Redirect in the rvalid cycle
    push(32'h300, 32'h304);
    budget = 2;
    wait_req("c3_wait_req");
    @(negedge clk);
    chk("c3_rvalid", 32'(bus.imem_rvalid), 32'd1);
    PCSrc    = 1'b1;
    PCTarget = 32'h300;
    @(posedge clk);
    #2;
    PCSrc = 1'b0;
    drain("drain_c3");

    // Misaligned redirect halts fetch
    budget   = 1;
    rv_delay = 3;
    wait_req("d_wait_req");
    @(posedge clk);
    #2;
    PCSrc    = 1'b1;
    PCTarget = 32'h102;
    budget   = 5;
    @(posedge clk);
    #2;
    PCSrc = 1'b0;
    repeat (8) begin
      @(negedge clk);
      chk("halt_misalign", 32'(fetch_misalign), 32'd1);
      chk("halt_req", 32'(bus.imem_req), 32'd0);
      chk("halt_valid", 32'(bus.instr_valid), 32'd0);
    end
    chk("halt_no_grant", 32'(budget), 32'd5);

    // Reset clears the sticky flag without a clock edge
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("rst2_misalign", 32'(fetch_misalign), 32'd0);
    @(posedge clk);
    #2;
    reset           = 1'b1;
    bus.instr_ready = 1'b0;
    budget          = 1;
    rv_delay        = 1;

    // Async reset while an output is held
    wait_valid("e1_wait_valid");
    reset = 1'b0;
    #1;
    chk("async_valid", 32'(bus.instr_valid), 32'd0);
    chk("async_pc4", bus.PCPlus4, 32'h4);

    // Async reset while a read is outstanding, then restart at RESET_PC
    @(posedge clk);
    #2;
    reset           = 1'b1;
    bus.instr_ready = 1'b1;
    rv_delay        = 3;
    budget          = 1;
    wait_req("e2_wait_req");
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("async_wait_req", 32'(bus.imem_req), 32'd0);
    chk("async_wait_valid", 32'(bus.instr_valid), 32'd0);
    @(posedge clk);
    #2;
    reset    = 1'b1;
    rv_delay = 1;
    budget   = 1;
    push(32'h0, 32'h4);
    drain("drain_e2");

    chk("wrap_count", 32'(widx), 32'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
